sha256_compress: RTL and testbench

SHA256_COMPRESS -- requirements
Module: SHA256_compress

---
 rtl/sha256_compress.sv | 176 +++++++++++++++++
 tb/tb_sha256_compress.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress.sv
// SHA-256 compression function, one round per clock.
// A job (message block plus chaining value) is accepted with a valid/ready
// handshake. Sixty-four rounds follow, with Kt fetched by address from an
// external constant memory. The updated hash is then held on a valid/yumi
// output until the consumer takes it.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a job; ready_o high
// S_ROUND | running rounds t = 0..63, one per cycle, Kt_addr_o = t
// S_DONE  | digest_o valid; waiting for yumi_i
module sha256_compress (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [511:0] block_i,
    input  logic [255:0] hash_i,
    output logic [6:0]   Kt_addr_o,
    input  logic [31:0]  Kt_i,
    output logic         v_o,
    output logic [255:0] digest_o,
    input  logic         yumi_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [5:0]   t_q, t_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    // Working variables a..h live at indices 0..7.
    logic [31:0]  wv_q [8];
    logic [31:0]  wv_d [8];
    // Chaining value H0..H7, kept for the final feed-forward addition.
    logic [31:0]  h_q [8];
    logic [31:0]  h_d [8];
    logic [255:0] digest_q, digest_d;

    logic [31:0]  t1, t2, w_new;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Round datapath: T1/T2 from the current working variables, and the next
    // schedule word derived from the 16-entry window (W[0] is Wt).
    always_comb begin
        t1    = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6])
              + Kt_i + w_q[0];
        t2    = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
        w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    end

    // Next-state logic for the control FSM and the whole datapath.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        w_d      = w_q;
        wv_d     = wv_q;
        h_d      = h_q;
        digest_d = digest_q;

        case (state_q)
            S_IDLE: begin
                if (v_i) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_i[511 - 32*i -: 32];
                    end
                    for (int i = 0; i < 8; i++) begin
                        h_d[i]  = hash_i[255 - 32*i -: 32];
                        wv_d[i] = hash_i[255 - 32*i -: 32];
                    end
                    t_d     = 6'd0;
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i+1];
                end
                w_d[15] = w_new;

                wv_d[0] = t1 + t2;
                wv_d[1] = wv_q[0];
                wv_d[2] = wv_q[1];
                wv_d[3] = wv_q[2];
                wv_d[4] = wv_q[3] + t1;
                wv_d[5] = wv_q[4];
                wv_d[6] = wv_q[5];
                wv_d[7] = wv_q[6];

                t_d = t_q + 6'd1;

                // The last round feeds forward straight into the output
                // register, so the digest is ready the cycle DONE is entered.
                if (t_q == 6'd63) begin
                    for (int i = 0; i < 8; i++) begin
                        digest_d[255 - 32*i -: 32] = h_q[i] + wv_d[i];
                    end
                    t_d     = 6'd0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (yumi_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            t_q      <= 6'd0;
            digest_q <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                wv_q[i] <= '0;
                h_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            digest_q <= digest_d;
            w_q      <= w_d;
            wv_q     <= wv_d;
            h_q      <= h_d;
        end
    end

    // Handshake and constant-memory address are decoded from the state.
    always_comb begin
        ready_o   = (state_q == S_IDLE);
        v_o       = (state_q == S_DONE);
        Kt_addr_o = (state_q == S_ROUND) ? {1'b0, t_q} : 7'd0;
        digest_o  = digest_q;
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: directed SHA-256 vectors; expected digests are
// queued at issue time and compared by a monitor when v_o rises.
module tb_sha256_compress;

    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         v_i;
    logic         ready_o;
    logic [511:0] block_i;
    logic [255:0] hash_i;
    logic [6:0]   Kt_addr_o;
    logic [31:0]  Kt_i;
    logic         v_o;
    logic [255:0] digest_o;
    logic         yumi_i;

    int tests = 0;
    int fails = 0;
    logic [255:0] exp_q [$];
    logic v_prev = 1'b0;

    sha256_compress dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .block_i   (block_i),
        .hash_i    (hash_i),
        .Kt_addr_o (Kt_addr_o),
        .Kt_i      (Kt_i),
        .v_o       (v_o),
        .digest_o  (digest_o),
        .yumi_i    (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    always_comb Kt_i = K_ROM[Kt_addr_o[5:0]];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new digest presentation is compared against the oldest
    // expectation in the scoreboard.
    always @(negedge clk_i) begin
        if (v_o === 1'b1 && v_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_digest: got %h expected none", digest_o);
            end else begin
                chk("digest", digest_o, exp_q.pop_front());
            end
        end
        v_prev = v_o;
    end

    // Wait (bounded) for v_o; returns number of negedges waited.
    task automatic wait_vo(output int n);
        n = 0;
        while (v_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (v_o !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL timeout_v_o: got v_o=%b expected 1", v_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n_i = 1'b0;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        block_i = '0;
        hash_i  = '0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;

        chk("rst_ready", 256'(ready_o), 256'd1);
        chk("rst_v_o", 256'(v_o), 256'd0);
        chk("rst_digest", digest_o, 256'd0);
        chk("rst_addr", 256'(Kt_addr_o), 256'd0);

        // "abc" with address sweep, latency and mid-job input change.
        v_i = 1'b1; block_i = B_ABC; hash_i = IV;
        exp_q.push_back(D_ABC);
        @(posedge clk_i); #1;
        v_i     = 1'b0;
        block_i = {16{$urandom}};
        hash_i  = {8{$urandom}};
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            chk("addr_sweep", 256'(Kt_addr_o), 256'(i));
            if (Kt_addr_o[6] !== 1'b0 || ready_o !== 1'b0 || v_o !== 1'b0)
                chk("round_ctrl", 256'({Kt_addr_o[6], ready_o, v_o}), 256'd0);
        end
        @(negedge clk_i);
        chk("latency_v_o", 256'(v_o), 256'd1);

        // Backpressure: hold DONE with v_i toggling and block_i changing.
        for (int i = 0; i < 10; i++) begin
            chk("bp_digest", digest_o, D_ABC);
            chk("bp_ctrl", 256'({v_o, ready_o, Kt_addr_o}), 256'({1'b1, 1'b0, 7'd0}));
            v_i     = ~v_i;
            block_i = {16{$urandom}};
            @(negedge clk_i);
        end
        v_i = 1'b0; yumi_i = 1'b1;
        @(negedge clk_i);
        yumi_i = 1'b0;
        chk("yumi_ready", 256'({ready_o, v_o}), 256'({1'b1, 1'b0}));
        chk("idle_retain", digest_o, D_ABC);

        // Back-to-back: empty string then "abc", v_i held, yumi_i held.
        v_i = 1'b1; block_i = B_EMPTY; hash_i = IV; yumi_i = 1'b1;
        exp_q.push_back(D_EMPTY);
        exp_q.push_back(D_ABC);
        @(posedge clk_i); #1;
        block_i = B_ABC;
        @(negedge clk_i);
        wait_vo(n);
        chk("b2b_latency1", 256'(n), 256'd64);
        @(negedge clk_i);
        chk("b2b_ready", 256'({ready_o, v_o}), 256'({1'b1, 1'b0}));
        @(negedge clk_i);
        chk("b2b_accept2", 256'({ready_o, v_o}), 256'd0);
        v_i = 1'b0;
        wait_vo(n);
        chk("b2b_latency2", 256'(n), 256'd64);
        @(negedge clk_i);
        yumi_i = 1'b0;
        chk("b2b_idle", 256'(ready_o), 256'd1);

        // Reset at t=30 aborts the job, with v_i asserted on the reset edge.
        v_i = 1'b1; block_i = B_ABC; hash_i = IV;
        @(posedge clk_i); #1;
        v_i = 1'b0;
        repeat (31) @(negedge clk_i);
        chk("abort_t30", 256'(Kt_addr_o), 256'd30);
        rst_n_i = 1'b0; v_i = 1'b1; yumi_i = 1'b1;
        @(negedge clk_i);
        rst_n_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
        chk("abort_ctrl", 256'({ready_o, v_o, Kt_addr_o}), 256'({1'b1, 1'b0, 7'd0}));
        chk("abort_digest", digest_o, 256'd0);
        repeat (80) @(negedge clk_i);
        chk("abort_no_vo", 256'(v_o), 256'd0);

        // First job after reset.
        v_i = 1'b1; block_i = B_ABC; hash_i = IV;
        exp_q.push_back(D_ABC);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        @(negedge clk_i);
        wait_vo(n);
        chk("post_rst_latency", 256'(n), 256'd64);
        yumi_i = 1'b1;
        @(negedge clk_i);
        yumi_i = 1'b0;
        repeat (2) @(negedge clk_i);

        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
